// File: rtl/ffs_pkg.sv
// Shared types for the set-bit iterator: FSM state encoding and default location width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ffs_pkg;

    // IDLE: nothing left to emit beyond the presented beat; SCAN: remaining mask still has bits
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEF_LOC_W = 16;

endpackage

// File: rtl/ffs_prio_enc.sv
// Priority encoder: picks the highest or lowest set bit of mask and returns mask with it cleared.
// Latency: purely combinational.
// Backpressure: none; no state.
module ffs_prio_enc #(
    parameter int WIDTH = 32,
    parameter int LOC_W = 16
) (
    input  logic [WIDTH-1:0] mask,
    input  logic             msb_first,
    output logic [LOC_W-1:0] index,
    output logic             hit,
    output logic [WIDTH-1:0] cleared
);

    logic [WIDTH-1:0] onehot;

    // Upward scan: in MSB mode later hits overwrite earlier ones, in LSB mode the first hit sticks
    always_comb begin
        index  = '0;
        hit    = 1'b0;
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i] && (msb_first || !hit)) begin
                index     = LOC_W'(i);
                hit       = 1'b1;
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
        cleared = mask & ~onehot;
    end

endmodule

// File: rtl/ffs_bit_iterator.sv
// Streams the index of every set bit of an accepted vector, one per beat, MSB- or LSB-first.
// Latency: first beat valid 1 cycle after accept; 1 index/cycle while out_rdy is high.
// Backpressure: out_* hold while out_vld && !out_rdy; in_rdy only when idle and the output slot frees.
// Optional: define FFS_POPCOUNT_EN to add out_popcnt (set-bit count of the accepted vector).
module ffs_bit_iterator
    import ffs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOC_W = DEF_LOC_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [WIDTH-1:0]             vector,
    input  logic                         msb_first,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [LOC_W-1:0]             out_location,
    output logic [LOC_W-1:0]             out_beat,
    output logic                         out_last,
`ifdef FFS_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0]   out_popcnt,
`endif
    output logic                         out_none
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic             vld_d, last_d, none_d;
    logic [LOC_W-1:0] loc_d, beat_d;

    logic [LOC_W-1:0] in_idx, rem_idx;
    logic             in_hit, rem_hit;
    logic [WIDTH-1:0] in_cleared, rem_cleared;
    logic             accept, advance;

    // Separate encoders keep the accept path and the remaining-mask path independent
    ffs_prio_enc #(.WIDTH(WIDTH), .LOC_W(LOC_W)) u_enc_in (
        .mask      (vector),
        .msb_first (msb_first),
        .index     (in_idx),
        .hit       (in_hit),
        .cleared   (in_cleared)
    );

    ffs_prio_enc #(.WIDTH(WIDTH), .LOC_W(LOC_W)) u_enc_rem (
        .mask      (remaining_q),
        .msb_first (dir_q),
        .index     (rem_idx),
        .hit       (rem_hit),
        .cleared   (rem_cleared)
    );

    assign in_rdy  = (state_q == IDLE) && (!out_vld || out_rdy);
    assign accept  = in_vld && in_rdy;
    assign advance = out_vld && out_rdy;

    // Next-state and next-beat selection: accept a new vector, step through the remaining mask, or drain
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        vld_d       = out_vld;
        loc_d       = out_location;
        beat_d      = out_beat;
        last_d      = out_last;
        none_d      = out_none;
        if (accept) begin
            vld_d       = 1'b1;
            loc_d       = in_idx;
            beat_d      = '0;
            none_d      = !in_hit;
            remaining_d = in_cleared;
            dir_d       = msb_first;
            last_d      = (in_cleared == '0);
            state_d     = (in_cleared == '0) ? IDLE : SCAN;
        end else if (advance && state_q == SCAN) begin
            // rem_hit is guaranteed in SCAN since remaining is nonzero there
            loc_d       = rem_hit ? rem_idx : '0;
            beat_d      = out_beat + LOC_W'(1);
            none_d      = 1'b0;
            remaining_d = rem_cleared;
            last_d      = (rem_cleared == '0);
            state_d     = (rem_cleared == '0) ? IDLE : SCAN;
        end else if (advance) begin
            vld_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            dir_q        <= 1'b0;
            out_vld      <= 1'b0;
            out_location <= '0;
            out_beat     <= '0;
            out_last     <= 1'b0;
            out_none     <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            dir_q        <= dir_d;
            out_vld      <= vld_d;
            out_location <= loc_d;
            out_beat     <= beat_d;
            out_last     <= last_d;
            out_none     <= none_d;
        end
    end

`ifdef FFS_POPCOUNT_EN
    logic [$clog2(WIDTH+1)-1:0] pop_in;

    // Set-bit count of the incoming vector
    always_comb begin
        pop_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_in = pop_in + ($clog2(WIDTH+1))'(vector[i]);
        end
    end

    // Count is captured once per accepted vector and held across all its beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_popcnt <= '0;
        end else if (accept) begin
            out_popcnt <= pop_in;
        end
    end
`endif

endmodule

// File: tb/tb_ffs_bit_iterator.sv
// Self-checking bench for ffs_bit_iterator (WIDTH=8): directed scenarios then random traffic.
// Reference: queue of expected beats built from the set bits of each accepted vector.
// Output port out_popcnt is checked when FFS_POPCOUNT_EN is defined.
module tb_ffs_bit_iterator;

    localparam int W = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [W-1:0]  vector;
    logic          msb_first;
    logic          out_vld;
    logic          out_rdy;
    logic [LW-1:0] out_location;
    logic [LW-1:0] out_beat;
    logic          out_last;
    logic          out_none;
`ifdef FFS_POPCOUNT_EN
    logic [$clog2(W+1)-1:0] out_popcnt;
`endif

    ffs_bit_iterator #(.WIDTH(W), .LOC_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .vector       (vector),
        .msb_first    (msb_first),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_location (out_location),
        .out_beat     (out_beat),
        .out_last     (out_last),
`ifdef FFS_POPCOUNT_EN
        .out_popcnt   (out_popcnt),
`endif
        .out_none     (out_none)
    );

    always #5 clk = ~clk;

    typedef struct {
        int loc;
        int beat;
        bit last;
        bit none;
        int pc;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat list for one vector: the set-bit indices in the requested order
    task automatic push_model(input logic [W-1:0] vec, input logic dir);
        int idx[$];
        beat_t b;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                if (dir) idx.push_front(i);
                else     idx.push_back(i);
            end
        end
        if (idx.size() == 0) begin
            b = '{loc: 0, beat: 0, last: 1'b1, none: 1'b1, pc: 0};
            q.push_back(b);
        end else begin
            for (int k = 0; k < idx.size(); k++) begin
                b = '{loc: idx[k], beat: k, last: (k == idx.size() - 1), none: 1'b0, pc: idx.size()};
                q.push_back(b);
            end
        end
    endtask

    // One cycle: drive inputs at negedge, check outputs against the model, then advance the model
    task automatic tick(input logic iv, input logic [W-1:0] vec, input logic dir, input logic ordy);
        logic exp_rdy;
        @(negedge clk);
        rst_n     = 1'b1;
        in_vld    = iv;
        vector    = vec;
        msb_first = dir;
        out_rdy   = ordy;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("out_vld", {31'b0, out_vld}, {31'b0, q.size() != 0});
        chk("in_rdy", {31'b0, in_rdy}, {31'b0, exp_rdy});
        if (q.size() != 0 && out_vld) begin
            chk("location", {16'b0, out_location}, q[0].loc);
            chk("beat", {16'b0, out_beat}, q[0].beat);
            chk("last", {31'b0, out_last}, {31'b0, q[0].last});
            chk("none", {31'b0, out_none}, {31'b0, q[0].none});
`ifdef FFS_POPCOUNT_EN
            chk("popcnt", 32'(out_popcnt), q[0].pc);
`endif
        end
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (iv && exp_rdy) push_model(vec, dir);
    endtask

    initial begin
        logic [W-1:0] rv;
        rst_n = 1'b0; in_vld = 1'b0; vector = '0; msb_first = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", {31'b0, out_vld}, 32'd0);
        chk("rst_location", {16'b0, out_location}, 32'd0);
        chk("rst_beat", {16'b0, out_beat}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);
        chk("rst_none", {31'b0, out_none}, 32'd0);
        chk("rst_in_rdy", {31'b0, in_rdy}, 32'd1);

        // 1: MSB-first 1010_0100 -> 7,5,2
        tick(1'b1, 8'b1010_0100, 1'b1, 1'b1);
        repeat (4) tick(1'b0, 8'h00, 1'b0, 1'b1);
        // 2: LSB-first -> 2,5,7
        tick(1'b1, 8'b1010_0100, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 8'h00, 1'b0, 1'b1);
        // 3: zero vector -> single none beat
        tick(1'b1, 8'h00, 1'b1, 1'b1);
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b1);
        // 4: all ones, stall 3 cycles while beat 3 is presented
        tick(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (q.size() != 0 && q[0].beat == 3 && i < 10) begin
                repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
            end
            tick(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("all_ones_drained", q.size(), 32'd0);
        // 5: back-to-back 81 then 01 with in_vld held high
        tick(1'b1, 8'h81, 1'b1, 1'b1);
        tick(1'b1, 8'h01, 1'b1, 1'b1);
        tick(1'b1, 8'h01, 1'b1, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        repeat (2) tick(1'b0, 8'h00, 1'b0, 1'b1);
        // 6: reset during SCAN of F0
        tick(1'b1, 8'hF0, 1'b1, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        q.delete();
        repeat (4) tick(1'b0, 8'hF0, 1'b1, 1'b1);

        // Random traffic with random backpressure and direction
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = '0;
                1:       rv = '1;
                default: rv = W'($urandom);
            endcase
            tick(($urandom_range(0, 2) != 0), rv, $urandom_range(0, 1) == 1, ($urandom_range(0, 3) != 0));
        end
        repeat (12) tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("final_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
